// File: rtl/drv_led_row.sv
// LED row driver: per-channel static/blink/pulse level select, gated by a shared PWM.
// Config macro DRV_LED_ACTIVE_LOW_EN inverts o_drv_led (lit = 0, reset all ones).
//
// Ports:
//   i_clk         : clock, all state updates on rising edge
//   i_rst         : synchronous active-high reset
//   i_led_on      : [p_COUNT]    static on request per channel
//   i_led_blink   : [p_COUNT]    blink request per channel
//   i_led_pulse   : [p_COUNT]    one-cycle strobe starting a timed pulse
//   i_bright      : [p_PWM_BITS] global brightness, 0 dark, all-ones full
//   o_drv_led     : [p_COUNT]    registered pin drive per channel
//   o_pulse_busy  : [p_COUNT]    pulse active, aligned with the drive output
//   o_busy_common : OR of o_pulse_busy
module drv_led_row #(
   parameter int p_COUNT     = 4,
   parameter int p_PWM_BITS  = 4,
   parameter int p_BLINK_DIV = 25000000,
   parameter int p_PULSE_LEN = 5000000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [p_COUNT-1:0]    i_led_on,
   input  logic [p_COUNT-1:0]    i_led_blink,
   input  logic [p_COUNT-1:0]    i_led_pulse,
   input  logic [p_PWM_BITS-1:0] i_bright,
   output logic [p_COUNT-1:0]    o_drv_led,
   output logic [p_COUNT-1:0]    o_pulse_busy,
   output logic                  o_busy_common
);

   localparam int lp_PW = (p_BLINK_DIV > 2) ? $clog2(p_BLINK_DIV) : 1;
   localparam int lp_TW = $clog2(p_PULSE_LEN + 1);

   // PWM period is 2^B-1 cycles so that all-ones brightness is always on.
   localparam logic [p_PWM_BITS-1:0] lp_PWM_MAX =
      p_PWM_BITS'((2 ** p_PWM_BITS) - 2);
   localparam logic [lp_PW-1:0] lp_PRESC_MAX = lp_PW'(p_BLINK_DIV - 1);
   localparam logic [lp_TW-1:0] lp_PULSE_LEN = lp_TW'(p_PULSE_LEN);

`ifdef DRV_LED_ACTIVE_LOW_EN
   localparam logic [p_COUNT-1:0] lp_POL = '1;
`else
   localparam logic [p_COUNT-1:0] lp_POL = '0;
`endif

   logic [p_PWM_BITS-1:0] r_pwm_cnt;
   logic [lp_PW-1:0]      r_presc;
   logic                  r_phase;
   logic [lp_TW-1:0]      r_timer [p_COUNT];
   logic [p_COUNT-1:0]    r_drv;
   logic [p_COUNT-1:0]    r_busy;

   logic                  w_pwm_on;
   logic [p_COUNT-1:0]    w_tmr_nz;
   logic [p_COUNT-1:0]    w_level;

   assign w_pwm_on = (r_pwm_cnt < i_bright);

   always_comb begin
      w_tmr_nz = '0;
      w_level  = '0;
      for (int i = 0; i < p_COUNT; i++) begin
         w_tmr_nz[i] = (r_timer[i] != '0);
         if (w_tmr_nz[i])
            w_level[i] = 1'b1;
         else if (i_led_blink[i])
            w_level[i] = r_phase;
         else if (i_led_on[i])
            w_level[i] = 1'b1;
         else
            w_level[i] = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pwm_cnt <= '0;
      end else if (r_pwm_cnt == lp_PWM_MAX) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   // Blink phase starts high so a blink request lights immediately after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc <= '0;
         r_phase <= 1'b1;
      end else if (r_presc == lp_PRESC_MAX) begin
         r_presc <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Strobe reloads (retrigger, no accumulation); reset aborts and drops strobes.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < p_COUNT; i++) begin
         if (i_rst)
            r_timer[i] <= '0;
         else if (i_led_pulse[i])
            r_timer[i] <= lp_PULSE_LEN;
         else if (w_tmr_nz[i])
            r_timer[i] <= r_timer[i] - 1'b1;
      end
   end

   // Busy is registered alongside the drive so both cover the same cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drv  <= lp_POL;
         r_busy <= '0;
      end else begin
         r_drv  <= (w_level & {p_COUNT{w_pwm_on}}) ^ lp_POL;
         r_busy <= w_tmr_nz;
      end
   end

   assign o_drv_led     = r_drv;
   assign o_pulse_busy  = r_busy;
   assign o_busy_common = |r_busy;

endmodule

// File: tb/tb_drv_led_row.sv
// Directed self-checking bench for drv_led_row.
// Small parameters: 4 channels, 2-bit PWM, blink div 4, pulse len 3.
module tb_drv_led_row;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] on, blink, pulse;
   logic [1:0] bright;
   logic [3:0] drv, busy;
   logic       busyc;
   int         checks = 0;
   int         errors = 0;

`ifdef DRV_LED_ACTIVE_LOW_EN
   localparam logic [3:0] MASK = 4'hF;
`else
   localparam logic [3:0] MASK = 4'h0;
`endif

   always #5 clk = ~clk;

   drv_led_row #(
      .p_COUNT(4), .p_PWM_BITS(2),
      .p_BLINK_DIV(4), .p_PULSE_LEN(3)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_led_on(on), .i_led_blink(blink),
      .i_led_pulse(pulse), .i_bright(bright),
      .o_drv_led(drv), .o_pulse_busy(busy),
      .o_busy_common(busyc)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; on = '0; blink = '0; pulse = '0; bright = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (drv !== MASK || busy !== 4'h0 || busyc !== 1'b0) begin
            errors++;
            $display("FAIL reset_during: drv=%b busy=%b common=%b want drv=%b busy=0000 common=0",
                     drv, busy, busyc, MASK);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (drv !== MASK || busy !== 4'h0 || busyc !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: drv=%b busy=%b common=%b want drv=%b",
                  drv, busy, busyc, MASK);
      end
   endtask

   task automatic test_pwm;
      logic [3:0] e;
      on = 4'b0001; blink = '0; pulse = '0; bright = 2'b01;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         tick();
         e = {3'b000, (i % 3 == 0)} ^ MASK;
         checks++;
         if (drv !== e) begin
            errors++;
            $display("FAIL pwm_b1[%0d]: drv=%b want %b", i, drv, e);
         end
      end
      bright = 2'b11;
      for (int i = 0; i < 6; i++) begin
         tick();
         e = 4'b0001 ^ MASK;
         checks++;
         if (drv !== e) begin
            errors++;
            $display("FAIL pwm_b3[%0d]: drv=%b want %b", i, drv, e);
         end
      end
      on = 4'b1111; bright = 2'b00;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (drv !== MASK) begin
            errors++;
            $display("FAIL pwm_b0[%0d]: drv=%b want %b", i, drv, MASK);
         end
      end
   endtask

   task automatic test_blink;
      logic [3:0] e;
      on = '0; blink = 4'b0010; pulse = '0; bright = 2'b11;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         tick();
         e = {2'b00, (((i >> 2) & 1) == 0), 1'b0} ^ MASK;
         checks++;
         if (drv !== e) begin
            errors++;
            $display("FAIL blink[%0d]: drv=%b want %b", i, drv, e);
         end
      end
   endtask

   task automatic test_pulse;
      logic [3:0] e;
      on = '0; blink = '0; pulse = '0; bright = 2'b11;
      do_reset();
      tick();
      pulse = 4'b0100;
      tick();
      pulse = '0;
      checks++;
      if (busy !== 4'h0) begin
         errors++;
         $display("FAIL pulse_k: busy=%b want 0000", busy);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         e = (i < 3) ? 4'b0100 : 4'b0000;
         checks++;
         if (drv !== (e ^ MASK) || busy !== e || busyc !== (e != 0)) begin
            errors++;
            $display("FAIL pulse[%0d]: drv=%b busy=%b common=%b want busy=%b",
                     i, drv, busy, busyc, e);
         end
      end
   endtask

   task automatic test_retrigger;
      logic [3:0] e;
      on = '0; blink = '0; pulse = '0; bright = 2'b11;
      do_reset();
      tick();
      pulse = 4'b0100;
      tick();
      pulse = '0;
      tick();
      pulse = 4'b0100;
      checks++;
      if (busy !== 4'b0100) begin
         errors++;
         $display("FAIL retrig_c1: busy=%b want 0100", busy);
      end
      tick();
      pulse = '0;
      for (int i = 0; i < 6; i++) begin
         e = (i < 4) ? 4'b0100 : 4'b0000;
         checks++;
         if (drv !== (e ^ MASK) || busy !== e) begin
            errors++;
            $display("FAIL retrig[%0d]: drv=%b busy=%b want busy=%b",
                     i + 2, drv, busy, e);
         end
         tick();
      end
   endtask

   task automatic test_priority;
      logic [3:0] e;
      on = 4'b0001; blink = '0; pulse = '0; bright = 2'b11;
      do_reset();
      tick();
      pulse = 4'b0001;
      tick();
      pulse = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         e = (i < 3) ? 4'b0001 : 4'b0000;
         checks++;
         if (drv !== (4'b0001 ^ MASK) || busy !== e) begin
            errors++;
            $display("FAIL prio[%0d]: drv=%b busy=%b want drv=%b busy=%b",
                     i, drv, busy, 4'b0001 ^ MASK, e);
         end
      end
   endtask

   task automatic test_reset_mid_pulse;
      on = 4'b1000; blink = '0; pulse = '0; bright = 2'b11;
      do_reset();
      tick();
      checks++;
      if (drv !== (4'b1000 ^ MASK)) begin
         errors++;
         $display("FAIL midrst_on: drv=%b want %b", drv, 4'b1000 ^ MASK);
      end
      pulse = 4'b1000;
      tick();
      pulse = '0;
      tick();
      checks++;
      if (busy !== 4'b1000) begin
         errors++;
         $display("FAIL midrst_busy: busy=%b want 1000", busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (drv !== MASK || busy !== 4'h0 || busyc !== 1'b0) begin
         errors++;
         $display("FAIL midrst_rst: drv=%b busy=%b want drv=%b busy=0000",
                  drv, busy, MASK);
      end
      pulse = 4'b1000;
      tick();
      pulse = '0;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (drv !== (4'b1000 ^ MASK) || busy !== 4'h0 || busyc !== 1'b0) begin
            errors++;
            $display("FAIL midrst_resume[%0d]: drv=%b busy=%b want drv=%b busy=0000",
                     i, drv, busy, 4'b1000 ^ MASK);
         end
      end
   endtask

   initial begin
      rst = 1'b1; on = '0; blink = '0; pulse = '0; bright = '0;
      test_reset();
      test_pwm();
      test_blink();
      test_pulse();
      test_retrigger();
      test_priority();
      test_reset_mid_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
